// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative unsigned multiply / divide unit.
// One radix-2 step per clock: shift-add for MUL/MULHU and restoring
// shift-subtract for DIVU/REMU. A divide by zero skips the iteration.
// Build option: define MUL_DIV_ZERO_SKIP_EN so that a multiply with a zero
// operand also skips the iteration and returns 0 one cycle after the start.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for i_start; operands are captured on an accepted start
// S_CALC | one shift-add / shift-subtract step per cycle, counter counts down
// S_DONE | o_done pulse; o_result valid; back to S_IDLE next cycle
module mul_div_seq #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [1:0]     op_r;
    // opnd_r holds the multiplicand (MUL) or the divisor (DIV).
    // lo_r holds the multiplier / low product half (MUL) or the
    // dividend shifting out while quotient bits shift in (DIV).
    // acc_r is the high product half (MUL) or the partial remainder (DIV).
    logic [W-1:0]   opnd_r, lo_r, acc_r, result_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r, done_r;

    logic           start_ok, div_zero, mul_zero, fast;
    logic [W-1:0]   fast_res;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           no_borrow;
    logic [W-1:0]   step_acc, step_lo, final_res;

    assign start_ok = i_start & ~i_flush;
    assign div_zero = i_op[1] & (i_operand_b == '0);
`ifdef MUL_DIV_ZERO_SKIP_EN
    assign mul_zero = ~i_op[1] & ((i_operand_a == '0) | (i_operand_b == '0));
`else
    assign mul_zero = 1'b0;
`endif
    assign fast     = div_zero | mul_zero;
    // Divide by zero: all-ones quotient, remainder is the dividend.
    assign fast_res = div_zero ? (i_op[0] ? i_operand_a : '1) : '0;

    // Single iteration step for both operation families.
    always_comb begin
        mul_sum   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
        div_shift = {acc_r, lo_r[W-1]};
        no_borrow = (div_shift >= {1'b0, opnd_r});
        if (op_r[1]) begin
            step_acc = no_borrow ? W'(div_shift - {1'b0, opnd_r}) : div_shift[W-1:0];
            step_lo  = {lo_r[W-2:0], no_borrow};
        end else begin
            step_acc = mul_sum[W:1];
            step_lo  = {mul_sum[0], lo_r[W-1:1]};
        end
        // op bit 0 selects high half / remainder over low half / quotient.
        final_res = op_r[0] ? step_acc : step_lo;
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_r <= (state_nx != S_IDLE);
            done_r <= (state_nx == S_DONE);
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt_r == '0) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (i_flush) state_nx = S_IDLE;
    end

    // Operand, accumulator, counter and result registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            op_r     <= '0;
            opnd_r   <= '0;
            lo_r     <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
        end else if (i_flush) begin
            cnt_r    <= '0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        op_r   <= i_op;
                        opnd_r <= i_op[1] ? i_operand_b : i_operand_a;
                        lo_r   <= i_op[1] ? i_operand_a : i_operand_b;
                        acc_r  <= '0;
                        cnt_r  <= CW'(W - 1);
                        if (fast) result_r <= fast_res;
                    end
                end
                S_CALC: begin
                    acc_r <= step_acc;
                    lo_r  <= step_lo;
                    if (cnt_r == '0) result_r <= final_res;
                    else             cnt_r    <= cnt_r - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = busy_r;
    // A flush during the DONE cycle still suppresses the pulse.
    assign o_done   = done_r & ~i_flush;
    assign o_result = result_r;

endmodule

// File: tb/tb_mul_div_seq.sv
module tb_mul_div_seq;

    localparam int W = 64;
    localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;
`ifdef MUL_DIV_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 65;
`endif

    logic         i_clk = 1'b0;
    logic         i_arst = 1'b1;
    logic         i_flush = 1'b0;
    logic         i_start = 1'b0;
    logic [1:0]   i_op = 2'b00;
    logic [W-1:0] i_operand_a = '0;
    logic [W-1:0] i_operand_b = '0;
    logic         o_busy, o_done;
    logic [W-1:0] o_result;

    int checks = 0;
    int errors = 0;

    mul_div_seq #(.DATA_WIDTH(W)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush), .i_start(i_start),
        .i_op(i_op), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Start one operation and watch it for lat+3 cycles after the start edge.
    task automatic run_vec(input int idx, input vec_t v);
        int first_k, ndone, busy_bad;
        logic [W-1:0] res_at_done;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge i_clk);
        i_op = v.op; i_operand_a = v.a; i_operand_b = v.b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_op = ~v.op;
        i_operand_a = 64'hDEAD_BEEF_0BAD_F00D;
        i_operand_b = 64'h0123_4567_89AB_CDEF;
        first_k = 0; ndone = 0; busy_bad = 0; res_at_done = '0;
        for (int k = 1; k <= v.lat + 3; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin
                ndone++;
                if (first_k == 0) begin
                    first_k = k;
                    res_at_done = o_result;
                end
            end
            if (o_busy !== (k <= v.lat)) busy_bad++;
        end
        check({tag, " latency"}, W'(first_k), W'(v.lat));
        check({tag, " done_count"}, W'(ndone), W'(1));
        check({tag, " busy_profile_errs"}, W'(busy_bad), W'(0));
        check({tag, " result_at_done"}, res_at_done, v.res);
        check({tag, " result_held"}, o_result, v.res);
    endtask

    initial begin
        int ndone, first_k;

        vecs[0]  = '{OP_MUL,   64'h0000_0001_0000_0003, 64'h5, 64'h0000_0005_0000_000F, 65};
        vecs[1]  = '{OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2]  = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65};
        vecs[3]  = '{OP_DIVU,  64'd100, 64'd7, 64'd14, 65};
        vecs[4]  = '{OP_REMU,  64'd100, 64'd7, 64'd2, 65};
        vecs[5]  = '{OP_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[6]  = '{OP_REMU,  64'd5, 64'd0, 64'd5, 1};
        vecs[7]  = '{OP_MUL,   64'd0, 64'd9, 64'd0, ZLAT};
        vecs[8]  = '{OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65};
        vecs[9]  = '{OP_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65};
        vecs[10] = '{OP_MULHU, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h1, 65};

        // Reset state
        repeat (2) @(negedge i_clk);
        check("reset busy", W'(o_busy), W'(0));
        check("reset done", W'(o_done), W'(0));
        check("reset result", o_result, '0);
        i_arst = 1'b0;
        @(negedge i_clk);
        check("post_reset busy", W'(o_busy), W'(0));

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Flush at N+20 together with a new start: flush wins
        @(negedge i_clk);
        i_op = OP_DIVU; i_operand_a = 64'd100; i_operand_b = 64'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (20) @(negedge i_clk);
        i_flush = 1'b1; i_start = 1'b1;
        i_op = OP_MUL; i_operand_a = 64'd3; i_operand_b = 64'd3;
        #1;
        check("flush calc done", W'(o_done), W'(0));
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        check("flush busy N+21", W'(o_busy), W'(0));
        check("flush done N+21", W'(o_done), W'(0));
        check("flush result", o_result, '0);
        ndone = 0; first_k = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) ndone++;
            if (o_busy !== 1'b0) first_k++;
        end
        check("flush dropped start done", W'(ndone), W'(0));
        check("flush dropped start busy", W'(first_k), W'(0));

        // Flush during the DONE cycle of a divide by zero
        @(negedge i_clk);
        i_op = OP_DIVU; i_operand_a = 64'd5; i_operand_b = 64'd0; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        check("dz result before flush", o_result, 64'hFFFF_FFFF_FFFF_FFFF);
        i_flush = 1'b1;
        #1;
        check("flush in done suppresses done", W'(o_done), W'(0));
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        @(negedge i_clk);
        check("flush in done result", o_result, '0);
        check("flush in done busy", W'(o_busy), W'(0));

        // Starts during CALC and DONE are ignored
        @(negedge i_clk);
        i_op = OP_MUL; i_operand_a = 64'd3; i_operand_b = 64'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        ndone = 0; first_k = 0;
        for (int k = 1; k <= 140; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin
                ndone++;
                if (first_k == 0) first_k = k;
            end
            i_start = (k == 10 || k == 65);
            i_op = OP_DIVU; i_operand_a = 64'd50; i_operand_b = 64'd0;
        end
        i_start = 1'b0;
        check("ignored starts latency", W'(first_k), W'(65));
        check("ignored starts done_count", W'(ndone), W'(1));
        check("ignored starts result", o_result, 64'd21);

        // Reset asserted at N+30 mid-operation
        @(negedge i_clk);
        i_op = OP_MULHU; i_operand_a = '1; i_operand_b = '1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (30) @(negedge i_clk);
        check("pre_reset busy", W'(o_busy), W'(1));
        i_arst = 1'b1;
        #1;
        check("midop reset busy", W'(o_busy), W'(0));
        check("midop reset done", W'(o_done), W'(0));
        check("midop reset result", o_result, '0);
        @(negedge i_clk);
        i_arst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) ndone++;
        end
        check("midop reset no done", W'(ndone), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
